divconv_ctrl: RTL and testbench
===============================

// Module: divconv_ctrl
// PURPOSE
// Control sequencer for the divconv Goldschmidt div/sqrt datapath, placed directly upstream of it.
// Accepts a start request, latches the operation attributes, then drives every divconv
// mux select and register load, one multiply pass per cycle. Runs IA, iteration,
// quotient-load and remainder passes, then signals done.
// PARAMETERS
// ITER_DP  3  refinement iterations, double precision (P=0); legal range 1..7
// ITER_SP  2  refinement iterations, single precision (P=1); legal range 1..7
// PORTS
// clk        in   1  clock, rising edge
// reset      in   1  asynchronous, active-low reset (0 = reset asserted)
// start      in   1  request; sampled only in IDLE
// op_in      in   1  0 = divide, 1 = sqrt; latched on accepted start
// p_in       in   1  1 = single precision; latched on accepted start
// odd_in     in   1  exponent odd (sqrt); latched on accepted start
// op_type    out  1  latched op, to divconv
// P          out  1  latched precision, to divconv
// exp_odd    out  1  latched odd flag, to divconv
// sel_muxa   out  3  divconv muxa select
// sel_muxb   out  3  divconv muxb select
// sel_muxr   out  1  remainder pass select
// load_rega  out  1  register load enables, to divconv
// load_regb  out  1
// load_regc  out  1
// load_regd  out  1
// load_regr  out  1
// load_regs  out  1
// busy       out  1  high in every state except IDLE
// done       out  1  one-cycle pulse; result registers are valid
// BEHAVIOUR
// Reset (async, reset=0): state=IDLE; all outputs 0; iteration counter 0.
// Moore machine: all outputs decode from registered state and registered flags only.
// Accept = start & IDLE at a rising edge. The op, P and odd flags latch on that edge.
// start is ignored when not in IDLE. Flags hold until the next accept.
// Pass encoding: muxa/muxb/loads. Unlisted loads are 0; unlisted selects are 000.
//   muxa codes: 000 regc, 001 n2, 010 ia, 011 regb, 100 regd.
//   muxb codes: 000 d2, 001 ia, 010 rega, 011 regc, 100 regd, 110 regb.
// Divide schedule:
//   D0: 010/000, loads a+c.
//   D1: 001/001, load b.
//   Then N iterations of DN (000/110, load b) followed by DD (000/010, loads a+c).
// Sqrt schedule:
//   S0: 010/001, load d.
//   S1: 100/000, loads a+c.
//   S2: 001/001, load b.
//   Then N iterations of SR (000/011, load d), SD (100/010, loads a+c), SN (000/110, load b).
// N = P ? ITER_SP : ITER_DP. The counter increments on the last pass of each iteration;
//   leave the loop when count == N-1 on that pass. Counter clears on accept.
// QLOAD: load_regs=1, selects 000.
// REM: sel_muxr=1, load_regr=1. Multiplier selects are don't-care; drive 000.
// DONE: done=1, busy=1. The next state is always IDLE.
// Latency, counting cycle 1 as the cycle after the accept edge:
//   divide: done high in cycle 2N+5.
//   sqrt: done high in cycle 3N+6.
// Reset mid-operation: immediate IDLE, outputs 0. No done pulse for the aborted op.
// start held high continuously: a new accept occurs in the IDLE cycle after DONE.
//   So the back-to-back period is (latency+1) cycles.
// Illegal state codes go to IDLE on the next edge.
// TESTING
// reset=0 mid-iteration -> all outputs 0 in the same cycle. Then start -> a clean D0 sequence.
// Divide, p_in=0: start pulse -> done in cycle 11. Exactly 3 DN/DD pairs. load_regs in cycle 9, load_regr in cycle 10.
// Sqrt, p_in=1, odd_in=1: -> done in cycle 12. exp_odd=1 and op_type=1 throughout. SR-SD-SN x2.
// start toggled during busy -> ignored, no schedule change. Latched flags unchanged when op_in flips.
// start held high -> DP divides at an 11+1 cycle period; busy low exactly 1 cycle between ops.
// Datapath-in-loop: divconv + ctrl with d=1.5, n=1.0 (DP) -> q1 = 0.666...; regr holds the residual.

Source files
------------

// File: rtl/divconv_ctrl.sv
// Goldschmidt div/sqrt sequencer for the divconv datapath.
// One multiply pass per cycle; all outputs decode from registered state.
module divconv_ctrl #(
  parameter int unsigned ITER_DP = 3,
  parameter int unsigned ITER_SP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_in,
  input  logic       p_in,
  input  logic       odd_in,
  output logic       op_type,
  output logic       P,
  output logic       exp_odd,
  output logic [2:0] sel_muxa,
  output logic [2:0] sel_muxb,
  output logic       sel_muxr,
  output logic       load_rega,
  output logic       load_regb,
  output logic       load_regc,
  output logic       load_regd,
  output logic       load_regr,
  output logic       load_regs,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    D0    = 4'd1,
    D1    = 4'd2,
    DN    = 4'd3,
    DD    = 4'd4,
    S0    = 4'd5,
    S1    = 4'd6,
    S2    = 4'd7,
    SR    = 4'd8,
    SD    = 4'd9,
    SN    = 4'd10,
    QLOAD = 4'd11,
    REM   = 4'd12,
    DONE  = 4'd13
  } state_e;

  localparam logic [2:0] LAST_DP = 3'(ITER_DP - 1);
  localparam logic [2:0] LAST_SP = 3'(ITER_SP - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       op_q, p_q, odd_q;
  logic       accept;
  logic       last_iter;

  assign accept    = start && (state_q == IDLE);
  assign last_iter = cnt_q == (p_q ? LAST_SP : LAST_DP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      p_q     <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q  <= op_in;
        p_q   <= p_in;
        odd_q <= odd_in;
      end
    end
  end

  // Counter steps on the closing pass of each iteration.
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = op_in ? S0 : D0;
          cnt_d   = '0;
        end
      end
      D0: state_d = D1;
      D1: state_d = DN;
      DN: state_d = DD;
      DD: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = last_iter ? QLOAD : DN;
      end
      S0: state_d = S1;
      S1: state_d = S2;
      S2: state_d = SR;
      SR: state_d = SD;
      SD: state_d = SN;
      SN: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = last_iter ? QLOAD : SR;
      end
      QLOAD:   state_d = REM;
      REM:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_muxa  = 3'b000;
    sel_muxb  = 3'b000;
    sel_muxr  = 1'b0;
    load_rega = 1'b0;
    load_regb = 1'b0;
    load_regc = 1'b0;
    load_regd = 1'b0;
    load_regr = 1'b0;
    load_regs = 1'b0;
    done      = 1'b0;
    busy      = state_q != IDLE;
    case (state_q)
      D0: begin
        sel_muxa  = 3'b010;
        load_rega = 1'b1;
        load_regc = 1'b1;
      end
      D1: begin
        sel_muxa  = 3'b001;
        sel_muxb  = 3'b001;
        load_regb = 1'b1;
      end
      DN: begin
        sel_muxb  = 3'b110;
        load_regb = 1'b1;
      end
      DD: begin
        sel_muxb  = 3'b010;
        load_rega = 1'b1;
        load_regc = 1'b1;
      end
      S0: begin
        sel_muxa  = 3'b010;
        sel_muxb  = 3'b001;
        load_regd = 1'b1;
      end
      S1: begin
        sel_muxa  = 3'b100;
        load_rega = 1'b1;
        load_regc = 1'b1;
      end
      S2: begin
        sel_muxa  = 3'b001;
        sel_muxb  = 3'b001;
        load_regb = 1'b1;
      end
      SR: begin
        sel_muxb  = 3'b011;
        load_regd = 1'b1;
      end
      SD: begin
        sel_muxa  = 3'b100;
        sel_muxb  = 3'b010;
        load_rega = 1'b1;
        load_regc = 1'b1;
      end
      SN: begin
        sel_muxb  = 3'b110;
        load_regb = 1'b1;
      end
      QLOAD: load_regs = 1'b1;
      REM: begin
        sel_muxr  = 1'b1;
        load_regr = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign op_type = op_q;
  assign P       = p_q;
  assign exp_odd = odd_q;

endmodule

// File: tb/tb_divconv_ctrl.sv
// Scoreboard bench for divconv_ctrl: a pass-list model feeds a queue
// that a negedge monitor drains while the sequencer is busy.
module tb_divconv_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, op_in, p_in, odd_in;
  logic       op_type, P, exp_odd;
  logic [2:0] sel_muxa, sel_muxb;
  logic       sel_muxr;
  logic       load_rega, load_regb, load_regc;
  logic       load_regd, load_regr, load_regs;
  logic       busy, done;

  divconv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_in     (op_in),
    .p_in      (p_in),
    .odd_in    (odd_in),
    .op_type   (op_type),
    .P         (P),
    .exp_odd   (exp_odd),
    .sel_muxa  (sel_muxa),
    .sel_muxb  (sel_muxb),
    .sel_muxr  (sel_muxr),
    .load_rega (load_rega),
    .load_regb (load_regb),
    .load_regc (load_regc),
    .load_regd (load_regd),
    .load_regr (load_regr),
    .load_regs (load_regs),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [2:0] a;
    logic [2:0] b;
    logic       r;
    logic [5:0] ld;
    logic       dn;
  } pass_t;

  pass_t      q[$];
  logic [2:0] fl_exp = 3'b000;
  int         errs = 0;
  int         checks = 0;
  int         ops_issued = 0;
  int         dones_seen = 0;

  // Load vector order is {a,b,c,d,r,s}.
  function automatic pass_t mk(string nm, logic [2:0] a,
                               logic [2:0] b, logic r,
                               logic [5:0] ld, logic dn);
    pass_t t;
    t.nm = nm; t.a = a; t.b = b;
    t.r = r; t.ld = ld; t.dn = dn;
    return t;
  endfunction

  function automatic int latency(bit op, bit p);
    int n = p ? 2 : 3;
    return op ? 3 * n + 6 : 2 * n + 5;
  endfunction

  function automatic void push_op(bit op, bit p);
    int n = p ? 2 : 3;
    if (!op) begin
      q.push_back(mk("D0", 3'b010, 3'b000, 0, 6'b101000, 0));
      q.push_back(mk("D1", 3'b001, 3'b001, 0, 6'b010000, 0));
      for (int i = 0; i < n; i++) begin
        q.push_back(mk("DN", 3'b000, 3'b110, 0, 6'b010000, 0));
        q.push_back(mk("DD", 3'b000, 3'b010, 0, 6'b101000, 0));
      end
    end else begin
      q.push_back(mk("S0", 3'b010, 3'b001, 0, 6'b000100, 0));
      q.push_back(mk("S1", 3'b100, 3'b000, 0, 6'b101000, 0));
      q.push_back(mk("S2", 3'b001, 3'b001, 0, 6'b010000, 0));
      for (int i = 0; i < n; i++) begin
        q.push_back(mk("SR", 3'b000, 3'b011, 0, 6'b000100, 0));
        q.push_back(mk("SD", 3'b100, 3'b010, 0, 6'b101000, 0));
        q.push_back(mk("SN", 3'b000, 3'b110, 0, 6'b010000, 0));
      end
    end
    q.push_back(mk("QLOAD", 3'b000, 3'b000, 0, 6'b000001, 0));
    q.push_back(mk("REM", 3'b000, 3'b000, 1, 6'b000010, 0));
    q.push_back(mk("DONE", 3'b000, 3'b000, 0, 6'b000000, 1));
  endfunction

  logic [5:0] ld_act;
  assign ld_act = {load_rega, load_regb, load_regc,
                   load_regd, load_regr, load_regs};

  always @(negedge clk) begin
    pass_t e;
    checks++;
    if (busy) begin
      if (q.size() == 0) begin
        errs++;
        $display("FAIL busy_extra t=%0t busy=1 required idle", $time);
      end else begin
        e = q.pop_front();
        if (sel_muxa !== e.a || sel_muxb !== e.b ||
            sel_muxr !== e.r || ld_act !== e.ld ||
            done !== e.dn ||
            {op_type, P, exp_odd} !== fl_exp) begin
          errs++;
          $display("FAIL pass_%s t=%0t got a=%b b=%b r=%b ld=%b dn=%b fl=%b req a=%b b=%b r=%b ld=%b dn=%b fl=%b",
                   e.nm, $time, sel_muxa, sel_muxb, sel_muxr,
                   ld_act, done, {op_type, P, exp_odd},
                   e.a, e.b, e.r, e.ld, e.dn, fl_exp);
        end
      end
    end else begin
      if (q.size() != 0 || sel_muxa !== 3'b000 ||
          sel_muxb !== 3'b000 || sel_muxr !== 1'b0 ||
          ld_act !== 6'b0 || done !== 1'b0 ||
          {op_type, P, exp_odd} !== fl_exp) begin
        errs++;
        $display("FAIL idle t=%0t got a=%b b=%b r=%b ld=%b dn=%b fl=%b pending=%0d req zeros fl=%b pending=0",
                 $time, sel_muxa, sel_muxb, sel_muxr, ld_act,
                 done, {op_type, P, exp_odd}, q.size(), fl_exp);
      end
    end
    if (done === 1'b1) dones_seen++;
  end

  // Start and attribute inputs are scrambled while busy; they must be ignored.
  task automatic issue(bit op, bit p, bit odd);
    int l = latency(op, p);
    @(negedge clk);
    start = 1'b1; op_in = op; p_in = p; odd_in = odd;
    @(posedge clk);
    push_op(op, p);
    fl_exp = {op, p, odd};
    ops_issued++;
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      start  = 1'($urandom);
      op_in  = 1'($urandom);
      p_in   = 1'($urandom);
      odd_in = 1'($urandom);
    end
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t sim did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0;
    op_in = 1'b0; p_in = 1'b0; odd_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    idle(2);
    issue(0, 0, 0);
    idle(2);
    issue(1, 1, 1);
    idle(1);
    issue(0, 0, 0);
    issue(0, 0, 0);
    issue(0, 0, 0);
    idle(1);
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 1'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    start = 1'b1; op_in = 1'b0; p_in = 1'b0; odd_in = 1'b1;
    @(posedge clk);
    push_op(0, 0);
    fl_exp = 3'b001;
    ops_issued++;
    repeat (4) @(negedge clk) start = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({sel_muxa, sel_muxb, sel_muxr, ld_act, done, busy,
         op_type, P, exp_odd} !== 19'b0) begin
      errs++;
      $display("FAIL async_reset got a=%b b=%b r=%b ld=%b dn=%b busy=%b fl=%b req all zero",
               sel_muxa, sel_muxb, sel_muxr, ld_act, done, busy,
               {op_type, P, exp_odd});
    end
    q.delete();
    fl_exp = 3'b000;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    issue(0, 0, 0);
    idle(3);
    checks++;
    if (dones_seen != ops_issued - 1) begin
      errs++;
      $display("FAIL done_count got %0d required %0d",
               dones_seen, ops_issued - 1);
    end
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
